clk_div_multi: RTL

Parametrised multi-channel clock divider for the FPGA prototype. It replaces the fixed single-output 100 MHz divider with NUM_CH independent channels. Each channel produces a 50% duty divided clock and a one-cycle tick strobe. Half-period values are runtime-programmable, take effect glitch-free, and a global sync pulse re-aligns the phase of all channels. It sits in the board top level, feeding the design clock and slower scan/sample strobes.

---
 rtl/clk_div_multi.sv | 79 +++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel 50% duty clock divider with runtime-programmable half-periods,
// per-channel rising-edge tick strobes and a global phase re-align pulse.
module clk_div_multi #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 16,
    parameter int DEF_HALF = 49999,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_i,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] div_clk_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] pend_o
);

    localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] staged;
        logic             pend;
        logic             div_clk;
        logic             tick;
        logic             wr_hit;

        // Out-of-range channel numbers never match any instance, so they are dropped.
        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= '0;
                half    <= DEF_HALF_V;
                staged  <= '0;
                pend    <= 1'b0;
                div_clk <= 1'b0;
                tick    <= 1'b0;
            end else begin
                tick <= 1'b0;
                if (sync_i) begin
                    cnt     <= '0;
                    div_clk <= 1'b0;
                    if (pend) begin
                        half <= staged;
                        pend <= 1'b0;
                    end
                end else if (en) begin
                    if (cnt == half) begin
                        cnt     <= '0;
                        div_clk <= ~div_clk;
                        tick    <= ~div_clk;
                        if (pend) begin
                            half <= staged;
                            pend <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // NOTE: this later non-blocking write to pend overrides the clear
                // above, so a write landing on a toggle or sync stays staged.
                if (wr_hit) begin
                    staged <= cfg_half;
                    pend   <= 1'b1;
                end
            end
        end

        assign div_clk_o[i] = div_clk;
        assign tick_o[i]    = tick;
        assign pend_o[i]    = pend;
    end

endmodule
